ct_fadd_close_pipe: RTL and testbench
=====================================

CT_FADD_CLOSE_PIPE -- requirements
Module: ct_fadd_close_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 12, close-path operand width (12 half, 25 single, 54 double).
REQ-002 SHALL have parameter IDXW, default 6, width of the ff1 index, at least clog2(WIDTH+1).
REQ-003 SHALL have port forever_cpuclk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port cpurst  input  1  synchronous active-high reset.
REQ-005 SHALL have port pipe_flush  input  1  kill all in-flight entries.
REQ-006 SHALL have port in_vld  input  1  operand valid.
REQ-007 SHALL have port in_rdy  output  1  block accepts operands this cycle.
REQ-008 SHALL have port close_adder0  input  WIDTH  minuend A.
REQ-009 SHALL have port close_adder1  input  WIDTH  subtrahend B.
REQ-010 SHALL have port abs_en  input  1  return a non-negative magnitude when A<B.
REQ-011 SHALL have port out_vld  output  1  result valid.
REQ-012 SHALL have port out_rdy  input  1  consumer accepts result.
REQ-013 SHALL have ports close_sum and close_sum_m1  output  WIDTH  difference and difference-plus-2.
REQ-014 SHALL have port close_op_chg  output  1  raw difference was negative.
REQ-015 SHALL have ports ff1_pred (output, IDXW) and ff1_pred_onehot (output, WIDTH)  predicted leading-one position.
REQ-016 SHALL have port close_zero  output  1  close_sum is all zero.

Function
REQ-017 SHALL be a two-stage pipeline, S1 (subtract + LZA vector) then S2 (priority encode), with each stage holding a valid bit; latency is exactly 2 cycles from an in_vld&&in_rdy cycle to out_vld when the consumer does not stall.
REQ-018 SHALL accept one transaction per cycle at full throughput when out_rdy stays high.
REQ-019 SHALL drive in_rdy = !s1_vld || (!s2_vld || out_rdy); a stage advances only when the next stage is empty or draining.
REQ-020 SHALL hold every output stable while out_vld && !out_rdy; S1 holds when S2 is blocked; no entry is dropped or duplicated.
REQ-021 SHALL compute raw = (A - B) mod 2^WIDTH, with close_op_chg = raw[WIDTH-1].
REQ-022 SHALL set swap = abs_en && raw[WIDTH-1]; close_sum = swap ? (B - A) : raw, and close_sum_m1 = close_sum + 2 mod 2^WIDTH.
REQ-023 SHALL build the LZA vector from operand pair (X,Y) = swap ? (B,A) : (A,B), using c=~Y, t=X^c, g=X&c, z=~X&~c.
REQ-024 SHALL form f[W-1] = g[W-1]&~z[W-2] | z[W-1]&~g[W-2], and f[0] = g[0] | z[0].
REQ-025 SHALL form each middle bit i as f[i] = t[i+1]&(g[i]&~z[i-1] | z[i]&~g[i-1]) | ~t[i+1]&(g[i]&~g[i-1] | z[i]&~z[i-1]).
REQ-026 SHALL compute both candidate f vectors in S1 and select by swap; the selected f is registered in S1.
REQ-027 SHALL in S2 set ff1_pred = number of leading zeros of f counted from bit WIDTH-1, with ff1_pred_onehot having a single 1 at that bit.
REQ-028 SHALL, when f is all zero, output ff1_pred = WIDTH and ff1_pred_onehot = 0; X outputs are forbidden.
REQ-029 SHALL guarantee that the true leading one of close_sum lies at the predicted position or one position to its right.
REQ-030 SHALL drive close_zero = (close_sum == 0).
REQ-031 SHALL on pipe_flush clear both valid bits at the next edge; flush wins over a simultaneous accept; in_rdy is unaffected.

Reset
REQ-032 SHALL while cpurst is high clear s1_vld and s2_vld and zero all data registers; outputs then read out_vld=0, close_sum=0, close_sum_m1=0, close_op_chg=0, ff1_pred=0, ff1_pred_onehot=0, close_zero=0.
REQ-033 SHALL drive in_rdy=0 while cpurst is high and in_rdy=1 on the first cycle after release.
REQ-034 SHALL discard an in-flight transaction when reset is asserted mid-operation, with no output for it.

Structure
REQ-035 SHALL take per-format WIDTH constants (half/single/double) and a clog2 function from shared package ct_fadd_pkg.
REQ-036 SHALL implement the f-vector generator as sub-module ct_fadd_lza_vec (parameter WIDTH), instantiated twice.

Verification
REQ-037 SHALL cover: WIDTH=12, A=0x400, B=0x3FF -> after 2 cycles close_sum=0x001, close_sum_m1=0x003, op_chg=0, ff1_pred 10 or 11.
REQ-038 SHALL cover: A=0x100, B=0x180, abs_en=1 -> close_sum=0x080, op_chg=1; same with abs_en=0 -> close_sum=0xF80.
REQ-039 SHALL cover: A=B=0x155 -> close_sum=0, close_zero=1, ff1_pred=12, ff1_pred_onehot=0.
REQ-040 SHALL cover: three back-to-back inputs with out_rdy=0 for 3 cycles -> in_rdy drops after 2 accepts, outputs stable, results then emerge in order.
REQ-041 SHALL cover: pipe_flush coincident with in_vld while 2 entries are in flight, then cpurst pulsed mid-pipe -> no out_vld for the flushed or reset entries.
REQ-042 SHALL cover: random A,B for WIDTH 12/25/54 -> all results match the reference model, and REQ-029 holds.

Source files
------------

// File: rtl/ct_fadd_pkg.sv
// Shared constants and helpers for the FADD close path.
// Per-format operand widths plus a constant clog2.
package ct_fadd_pkg;

  localparam int WIDTH_H = 12;
  localparam int WIDTH_S = 25;
  localparam int WIDTH_D = 54;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ct_fadd_close_pipe_if.sv
// Operand / result handshake bundle of the close-path pipe.
// master drives operands and consumes results.
interface ct_fadd_close_pipe_if
  import ct_fadd_pkg::*;
#(
  parameter int WIDTH = WIDTH_H,
  parameter int IDXW  = 6
) ();

  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] close_adder0;
  logic [WIDTH-1:0] close_adder1;
  logic             abs_en;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] close_sum;
  logic [WIDTH-1:0] close_sum_m1;
  logic             close_op_chg;
  logic [IDXW-1:0]  ff1_pred;
  logic [WIDTH-1:0] ff1_pred_onehot;
  logic             close_zero;

  modport master (
    output in_vld, close_adder0, close_adder1,
    output abs_en, out_rdy,
    input  in_rdy, out_vld, close_sum,
    input  close_sum_m1, close_op_chg,
    input  ff1_pred, ff1_pred_onehot, close_zero
  );

  modport slave (
    input  in_vld, close_adder0, close_adder1,
    input  abs_en, out_rdy,
    output in_rdy, out_vld, close_sum,
    output close_sum_m1, close_op_chg,
    output ff1_pred, ff1_pred_onehot, close_zero
  );

endinterface

// File: rtl/ct_fadd_lza_vec.sv
// Leading-zero anticipation indicator for X - Y.
// A set bit marks a candidate leading-one position.
module ct_fadd_lza_vec #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] f_o
);

  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] z;

  assign c = ~y_i;
  assign t = x_i ^ c;
  assign g = x_i & c;
  assign z = ~x_i & ~c;

  // Per-bit indicator; the MSB behaves as if t above it were 1
  always_comb begin
    f_o = '0;
    f_o[WIDTH-1] = (g[WIDTH-1] & ~z[WIDTH-2])
                 | (z[WIDTH-1] & ~g[WIDTH-2]);
    f_o[0] = g[0] | z[0];
    for (int i = 1; i < WIDTH - 1; i++) begin
      if (t[i+1])
        f_o[i] = (g[i] & ~z[i-1]) | (z[i] & ~g[i-1]);
      else
        f_o[i] = (g[i] & ~g[i-1]) | (z[i] & ~z[i-1]);
    end
  end

endmodule

// File: rtl/ct_fadd_close_pipe.sv
// FADD close path: S1 subtract + LZA vector, S2 ff1 encode.
// Two valid-bit stages with backpressure and flush.
module ct_fadd_close_pipe
  import ct_fadd_pkg::*;
#(
  parameter int WIDTH = WIDTH_H,
  parameter int IDXW  = 6
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             pipe_flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] close_adder0,
  input  logic [WIDTH-1:0] close_adder1,
  input  logic             abs_en,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] close_sum,
  output logic [WIDTH-1:0] close_sum_m1,
  output logic             close_op_chg,
  output logic [IDXW-1:0]  ff1_pred,
  output logic [WIDTH-1:0] ff1_pred_onehot,
  output logic             close_zero
);

  if (IDXW < clog2(WIDTH + 1)) begin : g_idxw_chk
    $error("IDXW too narrow for WIDTH");
  end

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0] s1_f_q, s1_f_d;
  logic             s1_chg_q, s1_chg_d;

  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
  logic [WIDTH-1:0] s2_m1_q, s2_m1_d;
  logic             s2_chg_q, s2_chg_d;
  logic [IDXW-1:0]  s2_pred_q, s2_pred_d;
  logic [WIDTH-1:0] s2_oh_q, s2_oh_d;
  logic             s2_zero_q, s2_zero_d;

  logic             s1_adv, s2_adv, accept;
  logic [WIDTH-1:0] raw, f_ab, f_ba;
  logic             swap;
  logic [IDXW-1:0]  enc_pred;
  logic [WIDTH-1:0] enc_oh;

  assign s2_adv = !s2_vld_q || out_rdy;
  assign s1_adv = !s1_vld_q || s2_adv;
  assign in_rdy = !cpurst && s1_adv;
  assign accept = in_vld && in_rdy;

  assign raw  = close_adder0 - close_adder1;
  assign swap = abs_en && raw[WIDTH-1];

  ct_fadd_lza_vec #(.WIDTH(WIDTH)) u_lza_ab (
    .x_i (close_adder0),
    .y_i (close_adder1),
    .f_o (f_ab)
  );

  ct_fadd_lza_vec #(.WIDTH(WIDTH)) u_lza_ba (
    .x_i (close_adder1),
    .y_i (close_adder0),
    .f_o (f_ba)
  );

  // S1 next state: capture difference and selected LZA vector
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_sum_d = s1_sum_q;
    s1_f_d   = s1_f_q;
    s1_chg_d = s1_chg_q;
    if (s1_adv) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_sum_d = swap ? (close_adder1 - close_adder0) : raw;
        s1_f_d   = swap ? f_ba : f_ab;
        s1_chg_d = raw[WIDTH-1];
      end
    end
    if (pipe_flush) s1_vld_d = 1'b0;
  end

  // Priority encode the leading one of f from the MSB down
  always_comb begin
    enc_pred = IDXW'(WIDTH);
    enc_oh   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_f_q[i]) begin
        enc_pred  = IDXW'(WIDTH - 1 - i);
        enc_oh    = '0;
        enc_oh[i] = 1'b1;
      end
    end
  end

  // S2 next state: result bundle presented to the consumer
  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_sum_d  = s2_sum_q;
    s2_m1_d   = s2_m1_q;
    s2_chg_d  = s2_chg_q;
    s2_pred_d = s2_pred_q;
    s2_oh_d   = s2_oh_q;
    s2_zero_d = s2_zero_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_sum_d  = s1_sum_q;
        s2_m1_d   = s1_sum_q + WIDTH'(2);
        s2_chg_d  = s1_chg_q;
        s2_pred_d = enc_pred;
        s2_oh_d   = enc_oh;
        s2_zero_d = (s1_sum_q == '0);
      end
    end
    if (pipe_flush) s2_vld_d = 1'b0;
  end

  // S1 registers
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_vld_q <= 1'b0;
      s1_sum_q <= '0;
      s1_f_q   <= '0;
      s1_chg_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_sum_q <= s1_sum_d;
      s1_f_q   <= s1_f_d;
      s1_chg_q <= s1_chg_d;
    end
  end

  // S2 registers
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s2_vld_q  <= 1'b0;
      s2_sum_q  <= '0;
      s2_m1_q   <= '0;
      s2_chg_q  <= 1'b0;
      s2_pred_q <= '0;
      s2_oh_q   <= '0;
      s2_zero_q <= 1'b0;
    end else begin
      s2_vld_q  <= s2_vld_d;
      s2_sum_q  <= s2_sum_d;
      s2_m1_q   <= s2_m1_d;
      s2_chg_q  <= s2_chg_d;
      s2_pred_q <= s2_pred_d;
      s2_oh_q   <= s2_oh_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  assign out_vld         = s2_vld_q;
  assign close_sum       = s2_sum_q;
  assign close_sum_m1    = s2_m1_q;
  assign close_op_chg    = s2_chg_q;
  assign ff1_pred        = s2_pred_q;
  assign ff1_pred_onehot = s2_oh_q;
  assign close_zero      = s2_zero_q;

endmodule

// File: tb/tb_ct_fadd_close_pipe.sv
// Bench for ct_fadd_close_pipe at half/single/double widths.
// Reference model with queues, plus directed literal checks.
module tb_ct_fadd_close_pipe;
  import ct_fadd_pkg::*;

  logic clk;
  logic cpurst;
  logic pipe_flush;
  int   nvec = 0;
  int   nerr = 0;

  ct_fadd_close_pipe_if #(.WIDTH(WIDTH_H), .IDXW(6)) if12 ();
  ct_fadd_close_pipe_if #(.WIDTH(WIDTH_S), .IDXW(6)) if25 ();
  ct_fadd_close_pipe_if #(.WIDTH(WIDTH_D), .IDXW(6)) if54 ();

  ct_fadd_close_pipe #(.WIDTH(WIDTH_H), .IDXW(6)) u12 (
    .forever_cpuclk  (clk),
    .cpurst          (cpurst),
    .pipe_flush      (pipe_flush),
    .in_vld          (if12.in_vld),
    .in_rdy          (if12.in_rdy),
    .close_adder0    (if12.close_adder0),
    .close_adder1    (if12.close_adder1),
    .abs_en          (if12.abs_en),
    .out_vld         (if12.out_vld),
    .out_rdy         (if12.out_rdy),
    .close_sum       (if12.close_sum),
    .close_sum_m1    (if12.close_sum_m1),
    .close_op_chg    (if12.close_op_chg),
    .ff1_pred        (if12.ff1_pred),
    .ff1_pred_onehot (if12.ff1_pred_onehot),
    .close_zero      (if12.close_zero)
  );

  ct_fadd_close_pipe #(.WIDTH(WIDTH_S), .IDXW(6)) u25 (
    .forever_cpuclk  (clk),
    .cpurst          (cpurst),
    .pipe_flush      (pipe_flush),
    .in_vld          (if25.in_vld),
    .in_rdy          (if25.in_rdy),
    .close_adder0    (if25.close_adder0),
    .close_adder1    (if25.close_adder1),
    .abs_en          (if25.abs_en),
    .out_vld         (if25.out_vld),
    .out_rdy         (if25.out_rdy),
    .close_sum       (if25.close_sum),
    .close_sum_m1    (if25.close_sum_m1),
    .close_op_chg    (if25.close_op_chg),
    .ff1_pred        (if25.ff1_pred),
    .ff1_pred_onehot (if25.ff1_pred_onehot),
    .close_zero      (if25.close_zero)
  );

  ct_fadd_close_pipe #(.WIDTH(WIDTH_D), .IDXW(6)) u54 (
    .forever_cpuclk  (clk),
    .cpurst          (cpurst),
    .pipe_flush      (pipe_flush),
    .in_vld          (if54.in_vld),
    .in_rdy          (if54.in_rdy),
    .close_adder0    (if54.close_adder0),
    .close_adder1    (if54.close_adder1),
    .abs_en          (if54.abs_en),
    .out_vld         (if54.out_vld),
    .out_rdy         (if54.out_rdy),
    .close_sum       (if54.close_sum),
    .close_sum_m1    (if54.close_sum_m1),
    .close_op_chg    (if54.close_op_chg),
    .ff1_pred        (if54.ff1_pred),
    .ff1_pred_onehot (if54.ff1_pred_onehot),
    .close_zero      (if54.close_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, got running want done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [63:0] sum;
    logic [63:0] m1;
    logic [63:0] oh;
    logic        chg;
    logic        zero;
    logic        c29;
    int          pred;
  } exp_t;

  function automatic int wd(int k);
    if (k == 0) return WIDTH_H;
    if (k == 1) return WIDTH_S;
    return WIDTH_D;
  endfunction

  function automatic string nm(string s, int k);
    return $sformatf("%s_w%0d", s, wd(k));
  endfunction

  // Reference: difference, abs swap and the LZA leading-one rule
  function automatic exp_t model(int w, logic [63:0] a_in,
                                 logic [63:0] b_in, logic ab);
    exp_t e;
    logic [63:0] mk, a, b, raw, x, y, c, t, g, z, f;
    logic sw;
    mk = (64'd1 << w) - 64'd1;
    a = a_in & mk;
    b = b_in & mk;
    raw = (a - b) & mk;
    e.chg = raw[w-1];
    sw = ab && e.chg;
    e.sum = sw ? ((b - a) & mk) : raw;
    e.m1 = (e.sum + 64'd2) & mk;
    e.zero = (e.sum == 64'd0);
    x = sw ? b : a;
    y = sw ? a : b;
    c = ~y & mk;
    t = x ^ c;
    g = x & c;
    z = ~x & ~c & mk;
    f = 64'd0;
    for (int i = 0; i < w; i++) begin
      if (i == 0)
        f[i] = g[0] | z[0];
      else if (i == w - 1)
        f[i] = (g[i] & ~z[i-1]) | (z[i] & ~g[i-1]);
      else if (t[i+1])
        f[i] = (g[i] & ~z[i-1]) | (z[i] & ~g[i-1]);
      else
        f[i] = (g[i] & ~g[i-1]) | (z[i] & ~z[i-1]);
    end
    e.pred = w;
    e.oh = 64'd0;
    for (int i = 0; i < w; i++) begin
      if (f[i]) begin
        e.pred = w - 1 - i;
        e.oh = 64'd1 << i;
      end
    end
    e.c29 = (x >= y) && (e.sum != 64'd0);
    return e;
  endfunction

  function automatic int lzc(int w, logic [63:0] v);
    for (int i = w - 1; i >= 0; i--)
      if (v[i]) return w - 1 - i;
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [63:0] m_a [3];
  logic [63:0] m_b [3];
  logic [63:0] m_sum [3];
  logic [63:0] m_m1 [3];
  logic [63:0] m_oh [3];
  logic [63:0] m_pred [3];
  logic        m_ab [3];
  logic        m_iv [3];
  logic        m_ir [3];
  logic        m_ov [3];
  logic        m_or [3];
  logic        m_chg [3];
  logic        m_zero [3];

  assign m_a[0]    = 64'(if12.close_adder0);
  assign m_b[0]    = 64'(if12.close_adder1);
  assign m_sum[0]  = 64'(if12.close_sum);
  assign m_m1[0]   = 64'(if12.close_sum_m1);
  assign m_oh[0]   = 64'(if12.ff1_pred_onehot);
  assign m_pred[0] = 64'(if12.ff1_pred);
  assign m_ab[0]   = if12.abs_en;
  assign m_iv[0]   = if12.in_vld;
  assign m_ir[0]   = if12.in_rdy;
  assign m_ov[0]   = if12.out_vld;
  assign m_or[0]   = if12.out_rdy;
  assign m_chg[0]  = if12.close_op_chg;
  assign m_zero[0] = if12.close_zero;

  assign m_a[1]    = 64'(if25.close_adder0);
  assign m_b[1]    = 64'(if25.close_adder1);
  assign m_sum[1]  = 64'(if25.close_sum);
  assign m_m1[1]   = 64'(if25.close_sum_m1);
  assign m_oh[1]   = 64'(if25.ff1_pred_onehot);
  assign m_pred[1] = 64'(if25.ff1_pred);
  assign m_ab[1]   = if25.abs_en;
  assign m_iv[1]   = if25.in_vld;
  assign m_ir[1]   = if25.in_rdy;
  assign m_ov[1]   = if25.out_vld;
  assign m_or[1]   = if25.out_rdy;
  assign m_chg[1]  = if25.close_op_chg;
  assign m_zero[1] = if25.close_zero;

  assign m_a[2]    = 64'(if54.close_adder0);
  assign m_b[2]    = 64'(if54.close_adder1);
  assign m_sum[2]  = 64'(if54.close_sum);
  assign m_m1[2]   = 64'(if54.close_sum_m1);
  assign m_oh[2]   = 64'(if54.ff1_pred_onehot);
  assign m_pred[2] = 64'(if54.ff1_pred);
  assign m_ab[2]   = if54.abs_en;
  assign m_iv[2]   = if54.in_vld;
  assign m_ir[2]   = if54.in_rdy;
  assign m_ov[2]   = if54.out_vld;
  assign m_or[2]   = if54.out_rdy;
  assign m_chg[2]  = if54.close_op_chg;
  assign m_zero[2] = if54.close_zero;

  exp_t        q [3][$];
  bit          hold_p [3];
  logic [63:0] h_sum [3];
  logic [63:0] h_pred [3];
  logic [63:0] h_oh [3];

  // Compare process: scoreboard pop, hold stability, model push
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      int   l;
      if (hold_p[k]) begin
        chk(nm("hold_vld", k), 64'(m_ov[k]), 64'd1);
        chk(nm("hold_sum", k), m_sum[k], h_sum[k]);
        chk(nm("hold_pred", k), m_pred[k], h_pred[k]);
        chk(nm("hold_oh", k), m_oh[k], h_oh[k]);
      end
      if (m_ov[k] === 1'b1)
        chk(nm("vld_pending", k), 64'(q[k].size() != 0), 64'd1);
      if (m_ov[k] === 1'b1 && m_or[k] === 1'b1 && q[k].size() != 0) begin
        e = q[k].pop_front();
        chk(nm("sum", k), m_sum[k], e.sum);
        chk(nm("sum_m1", k), m_m1[k], e.m1);
        chk(nm("op_chg", k), 64'(m_chg[k]), 64'(e.chg));
        chk(nm("zero", k), 64'(m_zero[k]), 64'(e.zero));
        chk(nm("ff1_pred", k), m_pred[k], 64'(e.pred));
        chk(nm("ff1_oh", k), m_oh[k], e.oh);
        if (e.c29) begin
          l = lzc(wd(k), m_sum[k]);
          chk(nm("lza_window", k),
              64'((64'(l) == m_pred[k]) || (64'(l) == m_pred[k] + 1)),
              64'd1);
        end
      end
      hold_p[k] = (m_ov[k] === 1'b1) && (m_or[k] === 1'b0);
      h_sum[k]  = m_sum[k];
      h_pred[k] = m_pred[k];
      h_oh[k]   = m_oh[k];
      if (cpurst || pipe_flush) begin
        q[k].delete();
        hold_p[k] = 1'b0;
      end else if (m_iv[k] === 1'b1 && m_ir[k] === 1'b1) begin
        q[k].push_back(model(wd(k), m_a[k], m_b[k], m_ab[k]));
      end
    end
  end

  task automatic drv12(input logic [11:0] a, input logic [11:0] b,
                       input logic ab, input logic v);
    if12.close_adder0 = a;
    if12.close_adder1 = b;
    if12.abs_en = ab;
    if12.in_vld = v;
  endtask

  // One isolated transaction: check 2-cycle latency, return outputs
  task automatic lat12(input logic [11:0] a, input logic [11:0] b,
                       input logic ab, output logic [63:0] s,
                       output logic [63:0] m, output logic [63:0] p,
                       output logic [63:0] oh, output logic ch,
                       output logic zr);
    @(posedge clk); #1;
    drv12(a, b, ab, 1'b1);
    @(negedge clk);
    chk("lat_accept", 64'(if12.in_rdy), 64'd1);
    @(posedge clk); #1;
    if12.in_vld = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_vld", 64'(if12.out_vld), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_vld", 64'(if12.out_vld), 64'd1);
    s  = 64'(if12.close_sum);
    m  = 64'(if12.close_sum_m1);
    p  = 64'(if12.ff1_pred);
    oh = 64'(if12.ff1_pred_onehot);
    ch = if12.close_op_chg;
    zr = if12.close_zero;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rb(logic [63:0] a);
    if ($urandom_range(0, 2) != 0)
      return a ^ 64'($urandom_range(0, 255));
    return rnd64();
  endfunction

  initial begin
    exp_t        e;
    logic [63:0] s, m, p, oh, a, b;
    logic        ch, zr;
    int          n;

    cpurst = 1'b1;
    pipe_flush = 1'b0;
    if12.in_vld = 1'b0; if12.out_rdy = 1'b1;
    if12.close_adder0 = '0; if12.close_adder1 = '0;
    if12.abs_en = 1'b0;
    if25.in_vld = 1'b0; if25.out_rdy = 1'b1;
    if25.close_adder0 = '0; if25.close_adder1 = '0;
    if25.abs_en = 1'b0;
    if54.in_vld = 1'b0; if54.out_rdy = 1'b1;
    if54.close_adder0 = '0; if54.close_adder1 = '0;
    if54.abs_en = 1'b0;

    e = model(12, 64'h400, 64'h3FF, 1'b0);
    chk("model_sum_400", e.sum, 64'h001);
    chk("model_m1_400", e.m1, 64'h003);
    chk("model_pred_400", 64'(e.pred == 10 || e.pred == 11), 64'd1);
    e = model(12, 64'h100, 64'h180, 1'b1);
    chk("model_sum_abs", e.sum, 64'h080);
    chk("model_pred_abs", 64'(e.pred), 64'd4);
    e = model(12, 64'h100, 64'h180, 1'b0);
    chk("model_sum_noabs", e.sum, 64'hF80);
    e = model(12, 64'h155, 64'h155, 1'b0);
    chk("model_pred_eq", 64'(e.pred), 64'd12);
    chk("model_oh_eq", e.oh, 64'd0);
    e = model(54, 64'd1 << 53, (64'd1 << 53) - 64'd1, 1'b0);
    chk("model_sum_d", e.sum, 64'd1);
    chk("model_pred_d", 64'(e.pred == 52 || e.pred == 53), 64'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", 64'(if12.in_rdy), 64'd0);
    chk("rst_out_vld", 64'(if12.out_vld), 64'd0);
    chk("rst_sum", 64'(if12.close_sum), 64'd0);
    chk("rst_sum_m1", 64'(if12.close_sum_m1), 64'd0);
    chk("rst_op_chg", 64'(if12.close_op_chg), 64'd0);
    chk("rst_pred", 64'(if12.ff1_pred), 64'd0);
    chk("rst_onehot", 64'(if12.ff1_pred_onehot), 64'd0);
    chk("rst_zero", 64'(if12.close_zero), 64'd0);
    @(posedge clk); #1;
    cpurst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", 64'(if12.in_rdy), 64'd1);

    lat12(12'h400, 12'h3FF, 1'b0, s, m, p, oh, ch, zr);
    chk("dir_400_sum", s, 64'h001);
    chk("dir_400_m1", m, 64'h003);
    chk("dir_400_chg", 64'(ch), 64'd0);
    chk("dir_400_pred", 64'(p == 10 || p == 11), 64'd1);

    lat12(12'h100, 12'h180, 1'b1, s, m, p, oh, ch, zr);
    chk("dir_abs_sum", s, 64'h080);
    chk("dir_abs_chg", 64'(ch), 64'd1);

    lat12(12'h100, 12'h180, 1'b0, s, m, p, oh, ch, zr);
    chk("dir_noabs_sum", s, 64'hF80);
    chk("dir_noabs_m1", m, 64'hF82);
    chk("dir_noabs_chg", 64'(ch), 64'd1);

    lat12(12'h155, 12'h155, 1'b0, s, m, p, oh, ch, zr);
    chk("dir_eq_sum", s, 64'h000);
    chk("dir_eq_zero", 64'(zr), 64'd1);
    chk("dir_eq_pred", p, 64'd12);
    chk("dir_eq_onehot", oh, 64'd0);

    // Backpressure: three back-to-back with the consumer stalled
    @(posedge clk); #1;
    if12.out_rdy = 1'b0;
    drv12(12'h200, 12'h001, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_acc1", 64'(if12.in_rdy), 64'd1);
    @(posedge clk); #1;
    drv12(12'h010, 12'h020, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_acc2", 64'(if12.in_rdy), 64'd1);
    @(posedge clk); #1;
    drv12(12'h7FF, 12'h7FE, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_in_rdy", 64'(if12.in_rdy), 64'd0);
    repeat (2) @(negedge clk);
    chk("stall_hold_sum", 64'(if12.close_sum), 64'h1FF);
    @(posedge clk); #1;
    if12.out_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if12.in_rdy !== 1'b1 && n < 10);
    chk("stall_drain_rdy", 64'(if12.in_rdy), 64'd1);
    @(posedge clk); #1;
    if12.in_vld = 1'b0;
    repeat (4) @(negedge clk);

    // Flush with two in flight and a coincident new operand
    @(posedge clk); #1;
    drv12(12'h300, 12'h100, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    drv12(12'h0F0, 12'h00F, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    drv12(12'h333, 12'h111, 1'b0, 1'b1);
    pipe_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_rdy", 64'(if12.in_rdy), 64'd1);
    @(posedge clk); #1;
    pipe_flush = 1'b0;
    if12.in_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_quiet", 64'(if12.out_vld), 64'd0);
    end

    // Reset pulse while an entry sits in S1
    @(posedge clk); #1;
    drv12(12'h456, 12'h123, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    if12.in_vld = 1'b0;
    cpurst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    cpurst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_quiet", 64'(if12.out_vld), 64'd0);
    end

    // Random traffic on all three widths with random stalls
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      a = rnd64(); b = rb(a);
      if12.close_adder0 = a[11:0];
      if12.close_adder1 = b[11:0];
      if12.abs_en = 1'($urandom_range(0, 1));
      if12.in_vld = ($urandom_range(0, 3) != 0);
      if12.out_rdy = ($urandom_range(0, 4) != 0);
      a = rnd64(); b = rb(a);
      if25.close_adder0 = a[24:0];
      if25.close_adder1 = b[24:0];
      if25.abs_en = 1'($urandom_range(0, 1));
      if25.in_vld = ($urandom_range(0, 3) != 0);
      if25.out_rdy = ($urandom_range(0, 4) != 0);
      a = rnd64(); b = rb(a);
      if54.close_adder0 = a[53:0];
      if54.close_adder1 = b[53:0];
      if54.abs_en = 1'($urandom_range(0, 1));
      if54.in_vld = ($urandom_range(0, 3) != 0);
      if54.out_rdy = ($urandom_range(0, 4) != 0);
    end
    @(posedge clk); #1;
    if12.in_vld = 1'b0; if12.out_rdy = 1'b1;
    if25.in_vld = 1'b0; if25.out_rdy = 1'b1;
    if54.in_vld = 1'b0; if54.out_rdy = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk(nm("drained", k), 64'(q[k].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
